// File: rtl/rx_fe_pkg.sv
// Shared constants and helpers for the receive-path ADC front end.
// Register offsets are relative to the block's settings-bus base address.
package rx_fe_pkg;

  localparam int IQ_W  = 18;
  localparam int ADC_W = 16;

  localparam int ADDR_SWAP  = 0;
  localparam int ADDR_MAG   = 1;
  localparam int ADDR_PHASE = 2;
  localparam int ADDR_DC_I  = 3;
  localparam int ADDR_DC_Q  = 4;

  // Clamp a 19-bit intermediate sum into the signed 18-bit I/Q range.
  function automatic logic signed [IQ_W-1:0] sat18(input logic signed [IQ_W:0] v);
    if (v[IQ_W] != v[IQ_W-1])
      return v[IQ_W] ? {1'b1, {(IQ_W-1){1'b0}}} : {1'b0, {(IQ_W-1){1'b1}}};
    return v[IQ_W-1:0];
  endfunction

endpackage

// File: rtl/rx_fe_dcoffset.sv
// Per-channel DC removal: subtracts either a fixed offset or a slowly tracked
// estimate (leaky integrator with time constant 2^ALPHA_SHIFT) and saturates.
module rx_fe_dcoffset
  import rx_fe_pkg::*;
#(
  parameter logic [7:0] ADDR        = 8'd0,
  parameter int         WIDTH       = 18,
  parameter int         ALPHA_SHIFT = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  input  logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] ofs
);

  logic                                fixed_mode;
  logic signed [WIDTH-1:0]             fixed_ofs;
  logic signed [ALPHA_SHIFT+WIDTH-1:0] acc;
  logic signed [WIDTH-1:0]             offset;
  logic signed [WIDTH:0]               diff;
  logic signed [WIDTH-1:0]             diff_sat;
  logic                                wr;
  logic                                unused_data;

  assign wr          = set_stb && (set_addr == ADDR);
  assign offset      = fixed_mode ? fixed_ofs : acc[ALPHA_SHIFT+WIDTH-1:ALPHA_SHIFT];
  assign diff        = {x[WIDTH-1], x} - {offset[WIDTH-1], offset};
  assign unused_data = ^set_data[30:WIDTH];

  always_comb begin
    diff_sat = diff[WIDTH-1:0];
    if (diff[WIDTH] != diff[WIDTH-1])
      diff_sat = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  // A control write reseeds the loop; otherwise the accumulator integrates the
  // unsaturated residual so the estimate converges even while the output clips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fixed_mode <= 1'b1;
      fixed_ofs  <= '0;
      acc        <= '0;
      ofs        <= '0;
    end else begin
      if (wr) begin
        fixed_mode <= set_data[31];
        if (set_data[31])
          fixed_ofs <= set_data[WIDTH-1:0];
        else
          acc <= {set_data[WIDTH-1:0], {ALPHA_SHIFT{1'b0}}};
      end else if (!fixed_mode) begin
        acc <= acc + {{(ALPHA_SHIFT-1){diff[WIDTH]}}, diff};
      end
      ofs <= diff_sat;
    end
  end

endmodule

// File: rtl/rx_front_end.sv
// Receive-path ADC front end: input register with optional I/Q swap, per-channel
// DC removal, IQ-imbalance (magnitude/phase) correction and 18-bit saturation.
module rx_front_end
  import rx_fe_pkg::*;
#(
  parameter int BASE        = 0,
  parameter int ALPHA_SHIFT = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  input  logic signed [ADC_W-1:0] adc_a,
  input  logic                    adc_ovf_a,
  input  logic signed [ADC_W-1:0] adc_b,
  input  logic                    adc_ovf_b,
  output logic signed [IQ_W-1:0]  i_out,
  output logic signed [IQ_W-1:0]  q_out,
  output logic                    run,
  output logic [31:0]             debug
);

  localparam logic [7:0] A_SWAP  = 8'(BASE + ADDR_SWAP);
  localparam logic [7:0] A_MAG   = 8'(BASE + ADDR_MAG);
  localparam logic [7:0] A_PHASE = 8'(BASE + ADDR_PHASE);
  localparam logic [7:0] A_DC_I  = 8'(BASE + ADDR_DC_I);
  localparam logic [7:0] A_DC_Q  = 8'(BASE + ADDR_DC_Q);

  logic                     swap_iq;
  logic signed [IQ_W-1:0]   mag_corr;
  logic signed [IQ_W-1:0]   phase_corr;
  logic signed [ADC_W-1:0]  adc_i;
  logic signed [ADC_W-1:0]  adc_q;
  logic                     ovf_a_r;
  logic                     ovf_b_r;
  logic signed [IQ_W-1:0]   x_i;
  logic signed [IQ_W-1:0]   x_q;
  logic signed [IQ_W-1:0]   ofs_i;
  logic signed [IQ_W-1:0]   ofs_q;
  logic signed [2*IQ_W-1:0] corr_i;
  logic signed [2*IQ_W-1:0] corr_q;
  logic signed [IQ_W:0]     sum_i;
  logic signed [IQ_W:0]     sum_q;
  logic                     unused_lsbs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_iq    <= 1'b0;
      mag_corr   <= '0;
      phase_corr <= '0;
    end else if (set_stb) begin
      if (set_addr == A_SWAP)  swap_iq    <= set_data[0];
      if (set_addr == A_MAG)   mag_corr   <= set_data[IQ_W-1:0];
      if (set_addr == A_PHASE) phase_corr <= set_data[IQ_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_i   <= '0;
      adc_q   <= '0;
      ovf_a_r <= 1'b0;
      ovf_b_r <= 1'b0;
      run     <= 1'b0;
    end else begin
      adc_i   <= swap_iq ? adc_b : adc_a;
      adc_q   <= swap_iq ? adc_a : adc_b;
      ovf_a_r <= adc_ovf_a;
      ovf_b_r <= adc_ovf_b;
      run     <= 1'b1;
    end
  end

  assign x_i = {adc_i, 2'b00};
  assign x_q = {adc_q, 2'b00};

  rx_fe_dcoffset #(.ADDR(A_DC_I), .WIDTH(IQ_W), .ALPHA_SHIFT(ALPHA_SHIFT)) dc_i (
    .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .x(x_i), .ofs(ofs_i)
  );

  rx_fe_dcoffset #(.ADDR(A_DC_Q), .WIDTH(IQ_W), .ALPHA_SHIFT(ALPHA_SHIFT)) dc_q (
    .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .x(x_q), .ofs(ofs_q)
  );

  // Both correction products are driven by I: the phase term leaks I into Q.
  assign corr_i      = ofs_i * mag_corr;
  assign corr_q      = ofs_i * phase_corr;
  assign sum_i       = {ofs_i[IQ_W-1], ofs_i} + {corr_i[2*IQ_W-1], corr_i[2*IQ_W-1:IQ_W]};
  assign sum_q       = {ofs_q[IQ_W-1], ofs_q} + {corr_q[2*IQ_W-1], corr_q[2*IQ_W-1:IQ_W]};
  assign unused_lsbs = ^{corr_i[IQ_W-1:0], corr_q[IQ_W-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_out <= '0;
      q_out <= '0;
    end else begin
      i_out <= sat18(sum_i);
      q_out <= sat18(sum_q);
    end
  end

  assign debug = {ovf_a_r, ovf_b_r, swap_iq, 11'b0, i_out};

endmodule

// File: tb/tb_rx_front_end.sv
// Scoreboard bench for rx_front_end: a driver pushes expected I/Q from an
// arithmetic model; a negedge monitor pops and compares when each result is due.
module tb_rx_front_end;
  import rx_fe_pkg::*;

  localparam int BASE  = 16;
  localparam int ASH   = 4;
  localparam int HIST  = 16384;

  logic               clk;
  logic               rst;
  logic               set_stb;
  logic [7:0]         set_addr;
  logic [31:0]        set_data;
  logic signed [15:0] adc_a;
  logic               adc_ovf_a;
  logic signed [15:0] adc_b;
  logic               adc_ovf_b;
  logic signed [17:0] i_out;
  logic signed [17:0] q_out;
  logic               run;
  logic [31:0]        debug;

  rx_front_end #(.BASE(BASE), .ALPHA_SHIFT(ASH)) dut (
    .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .adc_a(adc_a), .adc_ovf_a(adc_ovf_a), .adc_b(adc_b), .adc_ovf_b(adc_ovf_b),
    .i_out(i_out), .q_out(q_out), .run(run), .debug(debug)
  );

  typedef struct {
    int due;
    int i;
    int q;
  } exp_t;

  exp_t     sbq[$];
  logic [1:0] ovf_hist [HIST];
  logic       swap_hist[HIST];
  int       cyc = 0;
  int       n_checks = 0;
  int       n_fail = 0;

  int m_swap, m_mag, m_phase, m_off_i, m_off_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp18(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return int'(v);
  endfunction

  function automatic logic [31:0] enc18(input int v);
    return 32'(v) & 32'h0003_FFFF;
  endfunction

  function automatic int rand18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  function automatic void model_reset();
    m_swap = 0; m_mag = 0; m_phase = 0; m_off_i = 0; m_off_q = 0;
  endfunction

  function automatic void model_write(input int addr, input logic [31:0] d);
    int v;
    v = int'(d[17:0]);
    if (d[17]) v -= 262144;
    case (addr - BASE)
      ADDR_SWAP:  m_swap  = int'(d[0]);
      ADDR_MAG:   m_mag   = v;
      ADDR_PHASE: m_phase = v;
      ADDR_DC_I:  if (d[31]) m_off_i = v;
      ADDR_DC_Q:  if (d[31]) m_off_q = v;
      default: ;
    endcase
  endfunction

  // Expected output: scale ADC to 18 bits, subtract DC, add correction terms.
  function automatic void model_out(input int a, input int b, output int ei, output int eq);
    longint oi, oq;
    oi = clamp18(4 * longint'(m_swap != 0 ? b : a) - m_off_i);
    oq = clamp18(4 * longint'(m_swap != 0 ? a : b) - m_off_q);
    ei = clamp18(oi + ((oi * m_mag) >>> 18));
    eq = clamp18(oq + ((oi * m_phase) >>> 18));
  endfunction

  task automatic apply_stimulus(input int a, input int b, input bit oa, input bit ob,
                                input bit chk, input bit wr, input int addr,
                                input logic [31:0] data);
    int ei, eq;
    adc_a     = 16'(a);
    adc_b     = 16'(b);
    adc_ovf_a = oa;
    adc_ovf_b = ob;
    set_stb   = wr;
    set_addr  = 8'(addr);
    set_data  = data;
    if (chk) begin
      model_out(a, b, ei, eq);
      sbq.push_back('{cyc + 3, ei, eq});
    end
    if (cyc + 1 < HIST) ovf_hist[cyc + 1] = {oa, ob};
    if (wr) model_write(addr, data);
    if (cyc + 1 < HIST) swap_hist[cyc + 1] = (m_swap != 0);
    @(posedge clk);
    #1;
    set_stb = 1'b0;
  endtask

  task automatic sample(input int a, input int b, input bit chk);
    apply_stimulus(a, b, 1'b0, 1'b0, chk, 1'b0, 0, 32'd0);
  endtask

  task automatic write_reg(input int addr, input logic [31:0] data);
    apply_stimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, addr, data);
  endtask

  task automatic drain();
    repeat (3) sample(0, 0, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_i"}, i_out, 0);
    check_output({tag, "_q"}, q_out, 0);
    check_output({tag, "_run"}, run, 0);
    check_output({tag, "_debug"}, debug, 0);
  endtask

  // Monitor: compares the head of the scoreboard on the cycle it falls due.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] dexp;
    if (!rst && sbq.size() > 0) begin
      if (sbq[0].due < cyc) begin
        e = sbq.pop_front();
        check_output("missed_result", cyc, e.due);
      end else if (sbq[0].due == cyc) begin
        e = sbq.pop_front();
        dexp = {ovf_hist[cyc], swap_hist[cyc], 11'b0, 18'(e.i)};
        check_output("i_out", i_out, e.i);
        check_output("q_out", q_out, e.q);
        check_output("debug", debug, dexp);
        check_output("run", run, 1);
      end
    end
  end

  initial begin
    int ia;
    rst = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
    adc_a = '0; adc_b = '0; adc_ovf_a = 1'b0; adc_ovf_b = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    for (int k = 0; k < 20; k++) sample(4 * k, 0, 1'b1);
    drain();

    // Swap written on the same cycle as a sample: that sample keeps the old routing.
    apply_stimulus(100, -50, 1'b0, 1'b0, 1'b1, 1'b1, BASE + ADDR_SWAP, 32'd1);
    repeat (4) sample(100, -50, 1'b1);
    drain();
    write_reg(BASE + ADDR_SWAP, 32'd0);

    write_reg(BASE + ADDR_MAG, enc18(65536));
    sample(1000, 0, 1'b1);
    drain();
    write_reg(BASE + ADDR_MAG, enc18(131071));
    sample(32767, 0, 1'b1);
    sample(-32768, 0, 1'b1);
    drain();

    write_reg(BASE + ADDR_MAG, enc18(0));
    write_reg(BASE + ADDR_PHASE, enc18(-65536));
    repeat (3) sample(1000, 0, 1'b1);
    drain();

    write_reg(BASE + ADDR_PHASE, enc18(0));
    write_reg(BASE + ADDR_DC_I, 32'h8000_0190);
    repeat (3) sample(1000, 0, 1'b1);
    drain();

    write_reg(BASE + ADDR_DC_I, 32'h0000_0000);
    repeat (2000) sample(1000, 0, 1'b0);
    ia = int'(i_out);
    check_output("dc_track_converged", (ia < 8 && ia > -8) ? 1 : 0, 1);
    write_reg(BASE + ADDR_DC_I, 32'h8000_0000);
    drain();

    for (int burst = 0; burst < 8; burst++) begin
      drain();
      write_reg(BASE + ADDR_SWAP, {31'd0, 1'($urandom_range(0, 1))});
      write_reg(BASE + ADDR_MAG, enc18(rand18()));
      write_reg(BASE + ADDR_PHASE, enc18(rand18()));
      write_reg(BASE + ADDR_DC_I, 32'h8000_0000 | enc18(rand18()));
      write_reg(BASE + ADDR_DC_Q, 32'h8000_0000 | enc18(rand18()));
      write_reg(BASE + 5 + int'($urandom_range(0, 10)), $urandom);
      for (int n = 0; n < 30; n++)
        apply_stimulus(int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'b1, 1'b0, 0, 32'd0);
    end

    for (int k = 0; k < 10; k++) sample(4 * k, 0, 1'b1);
    rst = 1'b1;
    #1;
    check_idle("midreset");
    sbq.delete();
    model_reset();
    repeat (2) sample(0, 0, 1'b0);
    rst = 1'b0;
    sbq.push_back('{cyc + 1, 0, 0});
    sbq.push_back('{cyc + 2, 0, 0});
    for (int k = 5; k < 25; k++) sample(4 * k, 0, 1'b1);
    drain();
    check_output("scoreboard_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
